// File: rtl/vga_text_scanout.sv
// vga_text_scanout: raster scan of the text buffer through an 8x16 font ROM.
// Produces a 1-bit pixel stream with hsync, vsync, data-enable and a frame
// marker. All timing is derived from a pixel-rate strobe on clk48.
module vga_text_scanout #(
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 30,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk48,
  input  logic        rst_n,
  output logic [13:0] text_raddr,
  input  logic [7:0]  text_rdata,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        vga_pixel,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  // Pixel-rate divider
  logic [DIV_W-1:0] div;
  logic             pix_en;

  // Raster counters
  logic [10:0] h;
  logic [9:0]  v;

  // Stage 0 decode
  logic       visible;
  logic       hs_act;
  logic       vs_act;
  logic       first_px;
  logic [7:0] col;
  logic [5:0] row;
  logic       in_range;

  // Stage 1
  logic [3:0] line1;
  logic [2:0] col1;
  logic       vis1;
  logic       hs1;
  logic       vs1;
  logic       first1;

  // Stage 2
  logic [2:0] col2;
  logic       vis2;
  logic       hs2;
  logic       vs2;
  logic       first2;

  assign pix_en = (div == DIV_W'(PIX_DIV - 1));

  // Divider counts 0..PIX_DIV-1; pix_en marks its last count
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Horizontal and vertical position counters, advancing once per pixel
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == 11'(H_TOTAL - 1)) begin
        h <= '0;
        if (v == 10'(V_TOTAL - 1)) begin
          v <= '0;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Stage 0 raster decode straight from the counters
  always_comb begin
    visible  = (h < 11'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    hs_act   = (h >= 11'(H_ACTIVE + H_FP)) && (h < 11'(H_ACTIVE + H_FP + H_SYNC));
    vs_act   = (v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC));
    first_px = (h == '0) && (v == '0);
    col      = h[10:3];
    row      = v[9:4];
    // Extra guard keeps the address inside the buffer even if the active
    // area were configured wider than COLS*8 or taller than ROWS*16.
    in_range = ({1'b0, col} < 9'(COLS)) && ({1'b0, row} < 7'(ROWS));
  end

  // Stage 1: issue the text-buffer read and carry glyph position forward
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      text_raddr <= '0;
      line1      <= '0;
      col1       <= '0;
      vis1       <= 1'b0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      first1     <= 1'b0;
    end else if (pix_en) begin
      if (visible && in_range) begin
        text_raddr <= {row, col};
      end
      line1  <= v[3:0];
      col1   <= h[2:0];
      vis1   <= visible;
      hs1    <= hs_act;
      vs1    <= vs_act;
      first1 <= first_px;
    end
  end

  // Stage 2: character code plus glyph line forms the font ROM address
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      font_addr <= '0;
      col2      <= '0;
      vis2      <= 1'b0;
      hs2       <= 1'b0;
      vs2       <= 1'b0;
      first2    <= 1'b0;
    end else if (pix_en) begin
      font_addr <= {text_rdata, line1};
      col2      <= col1;
      vis2      <= vis1;
      hs2       <= hs1;
      vs2       <= vs1;
      first2    <= first1;
    end
  end

  // Stage 3: select the glyph bit and drive the aligned output pins
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      vga_pixel <= 1'b0;
      vga_de    <= 1'b0;
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
    end else if (pix_en) begin
      vga_pixel <= vis2 ? font_data[3'd7 - col2] : 1'b0;
      vga_de    <= vis2;
      vga_hsync <= hs2 ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= vs2 ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Frame marker lasts exactly one clk48, the cycle after stage 3 loads (0,0)
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & first2;
    end
  end

endmodule

// File: tb/tb_vga_text_scanout.sv
// Directed bench for vga_text_scanout using a shrunken raster so whole
// frames fit in a short run: 16x32 active, 24x38 total, 2x2 text cells.
module tb_vga_text_scanout;

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] text_raddr;
  logic [7:0]  text_rdata = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic        vga_pixel;
  logic        frame_start;

  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;
  logic force_ff = 1'b0;

  logic [7:0] tram [0:16383];
  logic [7:0] font [0:4095];

  vga_text_scanout #(
    .PIX_DIV (2),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .COLS    (2),
    .ROWS    (2),
    .SYNC_POL(1'b0)
  ) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .text_raddr (text_raddr),
    .text_rdata (text_rdata),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_de     (vga_de),
    .vga_pixel  (vga_pixel),
    .frame_start(frame_start)
  );

  always #5 clk48 = ~clk48;

  // synchronous 1-cycle memories
  always @(posedge clk48) begin
    text_rdata <= tram[text_raddr];
    font_data  <= force_ff ? 8'hFF : font[font_addr];
  end

  // address range monitor
  always @(negedge clk48) begin
    if (rst_n) begin
      checks++;
      assert ((text_raddr[7:0] < 8'd2) && (text_raddr[13:8] < 6'd2)) else begin
        failures++;
        $error("FAIL addr_range observed=%h expected=col<2,row<2", text_raddr);
      end
    end
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // advance to the negedge following posedge number 'target' since release
  task automatic step_to(input int target);
    while (k < target) begin
      @(posedge clk48);
      k++;
      @(negedge clk48);
    end
  endtask

  initial begin
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] g3;
    g0 = 8'h81;
    g1 = 8'h3C;
    g3 = 8'hA5;
    for (int i = 0; i < 16384; i++) tram[i] = 8'h00;
    for (int i = 0; i < 4096; i++) font[i] = 8'h00;
    tram[14'h0000] = 8'h41;
    tram[14'h0001] = 8'h42;
    tram[14'h0100] = 8'h43;
    tram[14'h0101] = 8'h44;
    font[12'h410]  = 8'h81;
    font[12'h420]  = 8'h3C;
    font[12'h413]  = 8'hA5;
    font[12'h44F]  = 8'h01;

    // reset state
    repeat (3) @(negedge clk48);
    chk_w("rst_raddr", 16'(text_raddr), 16'h0000);
    chk_w("rst_faddr", 16'(font_addr), 16'h0000);
    chk_b("rst_de", vga_de, 1'b0);
    chk_b("rst_pixel", vga_pixel, 1'b0);
    chk_b("rst_fs", frame_start, 1'b0);
    chk_b("rst_hsync", vga_hsync, 1'b1);
    chk_b("rst_vsync", vga_vsync, 1'b1);

    rst_n = 1'b1;
    k = 0;

    // first pixel pipeline: pix_en at edges 2,4,6...; pixel p out at edge 2p+6
    step_to(4);
    chk_w("faddr_p0", 16'(font_addr), 16'h0410);
    step_to(5);
    chk_b("fs_early", frame_start, 1'b0);
    step_to(6);
    chk_b("fs_first", frame_start, 1'b1);
    step_to(7);
    chk_b("fs_once", frame_start, 1'b0);

    // line 0 glyphs: cell (0,0) 0x81, cell (0,1) 0x3C
    for (int p = 0; p < 16; p++) begin
      step_to(2 * p + 6);
      chk_b("pix_l0", vga_pixel, (p < 8) ? g0[7 - p] : g1[15 - p]);
      chk_b("de_l0", vga_de, 1'b1);
    end
    step_to(36);
    chk_w("raddr_hold_h", 16'(text_raddr), 16'h0001);
    chk_w("faddr_c1", 16'(font_addr), 16'h0420);

    // horizontal blanking and hsync window h=18..20
    step_to(41);
    chk_b("hsync_pre", vga_hsync, 1'b1);
    step_to(42);
    chk_b("hsync_on", vga_hsync, 1'b0);
    chk_b("hblank_pix", vga_pixel, 1'b0);
    chk_b("hblank_de", vga_de, 1'b0);
    step_to(47);
    chk_b("hsync_end", vga_hsync, 1'b0);
    step_to(48);
    chk_b("hsync_post", vga_hsync, 1'b1);

    // glyph line 3 of cell (0,0): 0xA5
    step_to(148);
    chk_w("faddr_413", 16'(font_addr), 16'h0413);
    for (int i = 0; i < 8; i++) begin
      step_to(150 + 2 * i);
      chk_b("pix_l3", vga_pixel, g3[7 - i]);
    end

    // text row 1
    step_to(786);
    chk_w("raddr_0101", 16'(text_raddr), 16'h0101);
    step_to(1510);
    chk_b("pix_r1_c8", vga_pixel, 1'b0);
    step_to(1520);
    chk_w("raddr_last", 16'(text_raddr), 16'h0101);
    step_to(1522);
    chk_w("faddr_44f", 16'(font_addr), 16'h044F);
    step_to(1524);
    chk_b("pix_last", vga_pixel, 1'b1);

    // vertical blanking with font forced to all ones
    force_ff = 1'b1;
    step_to(1542);
    chk_b("vblank_pix", vga_pixel, 1'b0);
    chk_b("vblank_de", vga_de, 1'b0);
    chk_w("raddr_hold_v", 16'(text_raddr), 16'h0101);
    step_to(1637);
    chk_b("vsync_pre", vga_vsync, 1'b1);
    step_to(1638);
    chk_b("vsync_on", vga_vsync, 1'b0);
    step_to(1733);
    chk_b("vsync_end", vga_vsync, 1'b0);
    step_to(1734);
    chk_b("vsync_post", vga_vsync, 1'b1);
    force_ff = 1'b0;

    // second frame start: 912 pixels per frame
    step_to(1829);
    chk_b("fs2_early", frame_start, 1'b0);
    step_to(1830);
    chk_b("fs2", frame_start, 1'b1);
    chk_b("fs2_pix", vga_pixel, 1'b1);
    step_to(1831);
    chk_b("fs2_once", frame_start, 1'b0);

    // reset mid-line at h=5, v=0
    step_to(1840);
    chk_b("pre_rst_de", vga_de, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_b("mid_rst_de", vga_de, 1'b0);
    chk_b("mid_rst_pix", vga_pixel, 1'b0);
    chk_b("mid_rst_hs", vga_hsync, 1'b1);
    chk_b("mid_rst_vs", vga_vsync, 1'b1);
    chk_w("mid_rst_raddr", 16'(text_raddr), 16'h0000);
    chk_w("mid_rst_faddr", 16'(font_addr), 16'h0000);
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;
    k = 0;
    step_to(5);
    chk_b("rel_fs_early", frame_start, 1'b0);
    step_to(6);
    chk_b("rel_fs", frame_start, 1'b1);
    chk_b("rel_pix", vga_pixel, 1'b1);
    chk_b("rel_de", vga_de, 1'b1);
    step_to(7);
    chk_b("rel_fs_once", frame_start, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
